// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port arbiter and one-stage sequencer for the core's
//                single-port word-addressed data memory. Port 0 (core
//                load/store) has fixed priority; port 1 (debug/loader) gains
//                priority after being refused WAIT_LIMIT cycles in a row.
//                Accept -> access -> response, one transaction per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DEPTH      = 1024,
    parameter int WAIT_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [31:0] c_depth      = 32'(DEPTH);
    localparam logic [7:0]  c_wait_limit = 8'(WAIT_LIMIT);

    // Anti-starvation counter for port 1
    logic [7:0]  r_wait_cnt;

    // Access stage
    logic        r_s_valid;
    logic        r_s_owner;
    logic        r_s_we;
    logic [29:0] r_s_widx;
    logic [31:0] r_s_wdata;
    logic        r_s_err;

    // Response registers
    logic        r_m0_rvalid;
    logic [31:0] r_m0_rdata;
    logic        r_m0_err;
    logic        r_m1_rvalid;
    logic [31:0] r_m1_rdata;
    logic        r_m1_err;

    // Arbitration and selected request fields
    logic        w_m1_prio;
    logic        w_gnt_any;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_sel_err;
    logic [31:0] w_ld_data;

    // Port 1 overrides port 0 once it has waited WAIT_LIMIT cycles
    assign w_m1_prio = (r_wait_cnt == c_wait_limit) && m1_req;
    assign m0_gnt    = !rst && m0_req && !w_m1_prio;
    assign m1_gnt    = !rst && m1_req && (w_m1_prio || !m0_req);
    assign w_gnt_any = m0_gnt || m1_gnt;

    // Mux the granted requester's fields and classify the access
    always_comb begin
        w_sel_we    = m0_we;
        w_sel_addr  = m0_addr;
        w_sel_wdata = m0_wdata;
        if (m1_gnt) begin
            w_sel_we    = m1_we;
            w_sel_addr  = m1_addr;
            w_sel_wdata = m1_wdata;
        end
        w_sel_err = (w_sel_addr[1:0] != 2'b00) ||
                    ({2'b00, w_sel_addr[31:2]} >= c_depth);
    end

    // Count consecutive refusals of port 1, saturating at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= 8'd0;
        end else if (m1_req && !m1_gnt) begin
            if (r_wait_cnt < c_wait_limit) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end else begin
            r_wait_cnt <= 8'd0;
        end
    end

    // Latch the accepted request into the access stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_valid <= 1'b0;
            r_s_owner <= 1'b0;
            r_s_we    <= 1'b0;
            r_s_widx  <= 30'd0;
            r_s_wdata <= 32'd0;
            r_s_err   <= 1'b0;
        end else begin
            r_s_valid <= w_gnt_any;
            if (w_gnt_any) begin
                r_s_owner <= m1_gnt;
                r_s_we    <= w_sel_we;
                r_s_widx  <= w_sel_addr[31:2];
                r_s_wdata <= w_sel_wdata;
                r_s_err   <= w_sel_err;
            end
        end
    end

    // Memory drive; a reset clears r_s_valid so a pending store drops at once
    assign mem_a     = r_s_valid ? {2'b00, r_s_widx} : 32'd0;
    assign mem_wd    = (r_s_valid && r_s_we) ? r_s_wdata : 32'd0;
    assign mem_we    = r_s_valid && r_s_we && !r_s_err;
    assign w_ld_data = (!r_s_we && !r_s_err) ? mem_rd : 32'd0;

    // Capture the completion for the stage owner; everything else idles to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m0_rvalid <= 1'b0;
            r_m0_rdata  <= 32'd0;
            r_m0_err    <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m1_rdata  <= 32'd0;
            r_m1_err    <= 1'b0;
        end else begin
            r_m0_rvalid <= r_s_valid && !r_s_owner;
            r_m0_rdata  <= (r_s_valid && !r_s_owner) ? w_ld_data : 32'd0;
            r_m0_err    <= r_s_valid && !r_s_owner && r_s_err;
            r_m1_rvalid <= r_s_valid && r_s_owner;
            r_m1_rdata  <= (r_s_valid && r_s_owner) ? w_ld_data : 32'd0;
            r_m1_err    <= r_s_valid && r_s_owner && r_s_err;
        end
    end

    assign m0_rvalid = r_m0_rvalid;
    assign m0_rdata  = r_m0_rdata;
    assign m0_err    = r_m0_err;
    assign m1_rvalid = r_m1_rvalid;
    assign m1_rdata  = r_m1_rdata;
    assign m1_err    = r_m1_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Scoreboard bench for dmem_arbiter with a behavioural memory.
//                Stimulus pushes expected responses tagged with their due
//                cycle; a monitor pops and compares on every falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int c_depth = 1024;

    typedef struct packed {
        logic [31:0] due;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = 32'd0, m0_wdata = 32'd0;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = 32'd0, m1_wdata = 32'd0;
    logic        m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] mem [0:c_depth-1];
    logic        pl_we = 1'b0;
    logic [9:0]  pl_a = 10'd0;
    logic [31:0] pl_d = 32'd0;

    logic [31:0] cyc = 32'd0;
    int          n_chk  = 0;
    int          n_pass = 0;
    rsp_t        q0[$];
    rsp_t        q1[$];

    dmem_arbiter #(.DEPTH(c_depth), .WAIT_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory with combinational read
    assign mem_rd = (mem_a < 32'(c_depth)) ? mem[mem_a[9:0]] : 32'd0;
    always @(posedge clk) begin
        if (pl_we) mem[pl_a] <= pl_d;
        else if (mem_we && mem_a < 32'(c_depth)) mem[mem_a[9:0]] <= mem_wd;
    end

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: a due response must be present with the right payload,
    // otherwise the response outputs must be idle
    always @(negedge clk) begin
        rsp_t e;
        if (!rst) begin
            if (q0.size() > 0 && q0[0].due == cyc) begin
                e = q0.pop_front();
                chk("m0_rvalid", 64'(m0_rvalid), 64'd1);
                chk("m0_rdata", 64'(m0_rdata), 64'(e.data));
                chk("m0_err", 64'(m0_err), 64'(e.err));
            end else begin
                chk("m0_idle", 64'({m0_rvalid, m0_err, m0_rdata}), 64'd0);
            end
            if (q1.size() > 0 && q1[0].due == cyc) begin
                e = q1.pop_front();
                chk("m1_rvalid", 64'(m1_rvalid), 64'd1);
                chk("m1_rdata", 64'(m1_rdata), 64'(e.data));
                chk("m1_err", 64'(m1_err), 64'(e.err));
            end else begin
                chk("m1_idle", 64'({m1_rvalid, m1_err, m1_rdata}), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
        m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d;
    endtask

    task automatic set1(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
        m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d;
    endtask

    task automatic push0(input logic err, input logic [31:0] d);
        q0.push_back('{due: cyc + 32'd2, err: err, data: d});
    endtask

    task automatic push1(input logic err, input logic [31:0] d);
        q1.push_back('{due: cyc + 32'd2, err: err, data: d});
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_a = a; pl_d = d;
    endtask

    initial begin
        logic m1_turn;

        // Reset state, and gnt suppressed while rst is high
        m0_req = 1'b1;
        #2;
        chk("rst_gnt0", 64'(m0_gnt), 64'd0);
        chk("rst_outs", 64'({m0_rvalid, m0_err, m1_rvalid, m1_err, mem_we}), 64'd0);
        chk("rst_mem_a", 64'(mem_a), 64'd0);
        chk("rst_mem_wd", 64'(mem_wd), 64'd0);
        chk("rst_rdata", 64'({m0_rdata, m1_rdata}), 64'd0);
        m0_req = 1'b0;

        for (int i = 0; i < 8; i++) preload(10'(i), 32'hC0DE0000 | 32'(i));
        preload(10'd10, 32'h10101010);
        preload(10'd34, 32'hABCD1234);
        preload(10'd45, 32'h00000000);
        @(negedge clk);
        pl_we = 1'b0;
        tick();
        rst = 1'b0;

        // Simple m0 load of word 34
        tick(); set0(1, 0, 32'h88, 0); #4;
        chk("t1_gnt0", 64'(m0_gnt), 64'd1);
        chk("t1_gnt1", 64'(m1_gnt), 64'd0);
        push0(0, 32'hABCD1234);
        tick(); set0(0, 0, 0, 0); #4;
        chk("t1_mem_a", 64'(mem_a), 64'd34);
        chk("t1_mem_we", 64'(mem_we), 64'd0);
        tick(); tick();

        // m1 store then load of the same word: load sees new data
        tick(); set1(1, 1, 32'hB4, 32'hFFFFFFFF); #4;
        chk("t2_gnt1_st", 64'(m1_gnt), 64'd1);
        push1(0, 32'h0);
        tick(); set1(1, 0, 32'hB4, 0); #4;
        chk("t2_gnt1_ld", 64'(m1_gnt), 64'd1);
        chk("t2_mem_we", 64'(mem_we), 64'd1);
        chk("t2_mem_a", 64'(mem_a), 64'd45);
        chk("t2_mem_wd", 64'(mem_wd), 64'hFFFFFFFF);
        push1(0, 32'hFFFFFFFF);
        tick(); set1(0, 0, 0, 0); #4;
        chk("t2_mem_we_ld", 64'(mem_we), 64'd0);
        chk("t2_word45", 64'(mem[45]), 64'hFFFFFFFF);
        tick(); tick();

        // Both requesting continuously, WAIT_LIMIT = 4
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) begin
                set0(1, 0, 32'h4, 0);
                set1(1, 0, 32'h8, 0);
            end
            #4;
            m1_turn = (i == 4) || (i == 9);
            chk("t3_gnt0", 64'(m0_gnt), 64'(!m1_turn));
            chk("t3_gnt1", 64'(m1_gnt), 64'(m1_turn));
            if (m1_turn) push1(0, 32'hC0DE0002);
            else         push0(0, 32'hC0DE0001);
        end
        tick(); set0(0, 0, 0, 0); set1(0, 0, 0, 0);
        tick(); tick();

        // Misaligned store and out-of-range load
        tick(); set0(1, 1, 32'h1002, 32'hDEADBEEF); #4;
        chk("t4_gnt_st", 64'(m0_gnt), 64'd1);
        push0(1, 32'h0);
        tick(); set0(1, 0, 32'h1000, 0); #4;
        chk("t4_gnt_ld", 64'(m0_gnt), 64'd1);
        chk("t4_we_st", 64'(mem_we), 64'd0);
        push0(1, 32'h0);
        tick(); set0(0, 0, 0, 0); #4;
        chk("t4_we_ld", 64'(mem_we), 64'd0);
        chk("t4_mem_a", 64'(mem_a), 64'd1024);
        tick(); tick();

        // Reset during the access cycle of a store
        tick(); set0(1, 1, 32'h28, 32'h5A5A5A5A); #4;
        chk("t5_gnt", 64'(m0_gnt), 64'd1);
        tick(); set0(0, 0, 0, 0);
        chk("t5_we_pre", 64'(mem_we), 64'd1);
        rst = 1'b1;
        #1;
        chk("t5_we_drop", 64'(mem_we), 64'd0);
        chk("t5_mem_a", 64'(mem_a), 64'd0);
        chk("t5_mem_wd", 64'(mem_wd), 64'd0);
        #3;
        chk("t5_outs", 64'({m0_rvalid, m1_rvalid, m0_err, m1_err}), 64'd0);
        tick(); rst = 1'b0;
        tick(); tick();
        chk("t5_word10", 64'(mem[10]), 64'h10101010);

        // Back-to-back loads of words 0..7
        for (int i = 0; i < 8; i++) begin
            tick(); set0(1, 0, 32'(i) << 2, 0); #4;
            chk("t6_gnt", 64'(m0_gnt), 64'd1);
            push0(0, 32'hC0DE0000 | 32'(i));
        end
        tick(); set0(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick();

        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port word-addressed data memory of the single-cycle RISC-V core.
- Port 0 is the core load/store path. Port 1 is the debug/loader path.
- Each accepted request is registered, driven onto the memory for exactly one cycle, and completed with a one-cycle response pulse.
- Port 0 has fixed priority; port 1 has an anti-starvation override.

Parameters:
- DEPTH, 1024, number of 32-bit words in data memory; legal word index is 0..DEPTH-1.
- WAIT_LIMIT, 8, cycles port 1 may be refused before it gains priority; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- m0_req / m1_req  input  1  request valid; held with its fields until gnt.
- m0_we / m1_we  input  1  1 = store, 0 = load.
- m0_addr / m1_addr  input  32  byte address.
- m0_wdata / m1_wdata  input  32  store data.
- m0_gnt / m1_gnt  output  1  combinational accept, same cycle as req.
- m0_rvalid / m1_rvalid  output  1  registered completion pulse, one cycle, for loads and stores.
- m0_rdata / m1_rdata  output  32  load data, valid with rvalid; 0 for stores and errors.
- m0_err / m1_err  output  1  valid with rvalid; misaligned or out-of-range access.
- mem_we  output  1  to memory WE.
- mem_a  output  32  to memory A; word index.
- mem_wd  output  32  to memory WD.
- mem_rd  input  32  from memory RD; combinational read.

Behaviour:
- Reset (async, immediate):
  - stage valid, owner, response registers and wait counter cleared.
  - All rvalid, rdata and err outputs are 0.
  - mem_we = 0, mem_a = 0, mem_wd = 0.
  - gnt forced to 0 while rst is high.
- Arbitration, combinational, every cycle:
  - If wait_cnt == WAIT_LIMIT and m1_req: grant m1.
  - Else if m0_req: grant m0.
  - Else if m1_req: grant m1.
  - At most one gnt high per cycle. No backpressure: an accept is possible every cycle.
- Wait counter (8-bit):
  - Increments while m1_req is high and m1_gnt is low; saturates at WAIT_LIMIT.
  - Clears on m1_gnt or when m1_req is low.
- Cycle N (accept): on the edge ending N, the granted fields are latched into the stage as s_valid = 1, s_owner, s_we, s_widx = addr[31:2], s_wdata.
  - s_err = (addr[1:0] != 0) or (addr[31:2] >= DEPTH).
  - If no grant, s_valid = 0.
- Cycle N+1 (access):
  - mem_a = s_widx when s_valid, else 0.
  - mem_wd = s_wdata when s_valid & s_we, else 0.
  - mem_we = s_valid & s_we & ~s_err.
  - The memory commits the store on the edge ending N+1.
  - On that same edge, the owner's rdata register takes mem_rd for a non-error load, else 0.
  - The owner's err register takes s_err. The owner's rvalid is set; the other port's rvalid is cleared.
- Cycle N+2 (response): rvalid/rdata/err are visible for exactly one cycle, then return to 0 unless another completion follows.
- Latency: accept-to-response is 2 cycles. Throughput is 1 transaction per cycle.
- Ordering:
  - Transactions complete in accept order.
  - A load accepted in the cycle a store is in access stage reads the new data: the store commits before the load's access cycle.
- Errored accesses: never assert mem_we, return rdata 0, err 1.
- Simultaneous requests: the loser keeps req high and receives no gnt. Its fields are not sampled.
- Reset mid-transaction: a store in the stage is dropped (mem_we falls asynchronously) and no response is issued. Requesters must reissue.

Test Plan:
- Preload word 34 = 0xABCD1234; m0 load at addr 0x88 in cycle 0 -> m0_gnt cycle 0, mem_a = 34 and mem_we = 0 in cycle 1, m0_rvalid = 1 with m0_rdata = 0xABCD1234 and err = 0 in cycle 2.
- m1 store 0xFFFFFFFF to 0xB4 in cycle 0, m1 load 0xB4 in cycle 1 -> mem_we = 1, mem_a = 45 in cycle 1; word 45 = 0xFFFFFFFF; load rvalid in cycle 3 with rdata 0xFFFFFFFF.
- m0_req and m1_req held high continuously, WAIT_LIMIT = 4 -> m0 granted cycles 0-3, m1 granted cycle 4, m0 cycles 5-8, m1 cycle 9; never two gnts in one cycle.
- m0 store to 0x1002 (misaligned), then m0 load at 0x1000 with DEPTH = 1024 (word 1024, out of range) -> mem_we stays 0, both responses have err = 1 and rdata = 0, memory unchanged.
- m0 store to word 10 accepted, rst pulsed mid access cycle -> mem_we drops immediately, word 10 unchanged, no rvalid, all outputs 0; normal operation resumes after release.
- m0 loads of words 0..7 on consecutive cycles -> eight consecutive m0_rvalid pulses in cycles 2..9 with data in address order.
